// File: rtl/serial_pkg.sv
// Types and constants shared by the serial transmit/receive pair.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } state_t;

    // Frame width shared with the deserializer so both ends agree on framing.
    localparam int SERIAL_WIDTH = 8;

endpackage

// File: rtl/serializador.sv
// Parallel-to-serial transmitter: captures a word on valid/ack, sends it MSB-first framed by write_out.
// Optional even-parity bit after each frame when SERIALIZADOR_PARITY_EN is defined.
module serializador
    import serial_pkg::*;
#(
    parameter int WIDTH      = SERIAL_WIDTH,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk_100KHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ack_out,
    output logic             data_out,
    output logic             write_out,
    output logic             status_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [GAP_W-1:0]   gap_q;
    logic               ack_q;
`ifdef SERIALIZADOR_PARITY_EN
    logic               parity_q;
`endif

    always_ff @(posedge clk_100KHz or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            ack_q    <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        state_q  <= SHIFT;
                        shift_q  <= data_in;
                        cnt_q    <= '0;
                        ack_q    <= 1'b1;
`ifdef SERIALIZADOR_PARITY_EN
                        parity_q <= ^data_in;
`endif
                    end
                end
                SHIFT: begin
                    shift_q <= {shift_q[WIDTH-2:0], 1'b0};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        gap_q <= '0;
`ifdef SERIALIZADOR_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= GAP;
`endif
                    end
                end
`ifdef SERIALIZADOR_PARITY_EN
                PARITY: begin
                    state_q <= GAP;
                    gap_q   <= '0;
                end
`endif
                GAP: begin
                    // The idle gap keeps back-to-back frames distinguishable at the receiver.
                    if (gap_q == LAST_GAP) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line outputs decode registered state only, so the line drops as soon as reset asserts.
    always_comb begin
        data_out  = 1'b0;
        write_out = 1'b0;
        case (state_q)
            SHIFT: begin
                data_out  = shift_q[WIDTH-1];
                write_out = 1'b1;
            end
`ifdef SERIALIZADOR_PARITY_EN
            PARITY: begin
                data_out  = parity_q;
                write_out = 1'b1;
            end
`endif
            default: begin
                data_out  = 1'b0;
                write_out = 1'b0;
            end
        endcase
    end

    assign ack_out    = ack_q;
    assign status_out = (state_q != IDLE);

endmodule

// File: tb/tb_serializador.sv
// Scoreboard bench for serializador; honours SERIALIZADOR_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_serializador;

`ifdef SERIALIZADOR_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_LEN = 8 + PAR;

    logic       clk_100KHz;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ack_out;
    logic       data_out;
    logic       write_out;
    logic       status_out;

    int checks;
    int errors;
    int ack_cnt;
    logic [8:0] exp_q[$];

    serializador dut (
        .clk_100KHz (clk_100KHz),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ack_out    (ack_out),
        .data_out   (data_out),
        .write_out  (write_out),
        .status_out (status_out)
    );

    initial clk_100KHz = 1'b0;
    always #5000 clk_100KHz = ~clk_100KHz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected frame: the byte, followed by its hand-computed even parity bit when enabled.
    task automatic push_exp(input logic [7:0] b, input logic p);
        if (PAR == 1) exp_q.push_back({b, p});
        else          exp_q.push_back({1'b0, b});
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk_100KHz);
            n++;
        end while (!ack_out && n < 40);
        check("ack_seen", ack_out, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (status_out && n < 40) begin
            @(negedge clk_100KHz);
            n++;
        end
        check("back_to_idle", status_out, 0);
        repeat (2) @(negedge clk_100KHz);
    endtask

    task automatic send(input logic [7:0] b, input logic p);
        int n;
        data_in  = b;
        valid_in = 1'b1;
        push_exp(b, p);
        wait_ack(n);
        valid_in = 1'b0;
        data_in  = 8'h00;
        wait_idle();
    endtask

    // Monitor: assembles each write_out-framed burst and compares it with the scoreboard.
    initial begin
        logic [8:0] fr;
        logic [8:0] ev;
        int len;
        fr  = '0;
        len = 0;
        forever begin
            @(negedge clk_100KHz);
            if (!reset) begin
                fr  = '0;
                len = 0;
            end else begin
                if (ack_out) ack_cnt++;
                if (write_out) begin
                    fr = {fr[7:0], data_out};
                    len++;
                end else begin
                    check("idle_line_low", data_out, 0);
                    if (len > 0) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame got %0h expected none", fr);
                        end else begin
                            ev = exp_q.pop_front();
                            check("frame_data", fr, ev);
                            check("frame_len", len, FRAME_LEN);
                        end
                        fr  = '0;
                        len = 0;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int st;
        int ack0;
        logic seen;
        checks   = 0;
        errors   = 0;
        ack_cnt  = 0;
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;

        #3000;
        check("rst_ack", ack_out, 0);
        check("rst_data", data_out, 0);
        check("rst_write", write_out, 0);
        check("rst_status", status_out, 0);
        repeat (2) @(negedge clk_100KHz);
        reset = 1'b1;
        repeat (2) @(negedge clk_100KHz);

        // Single frame 0xA5: one ack, status spans bits plus gap.
        ack0     = ack_cnt;
        data_in  = 8'hA5;
        valid_in = 1'b1;
        push_exp(8'hA5, 1'b0);
        wait_ack(n);
        valid_in = 1'b0;
        data_in  = 8'h00;
        check("t1_ack_latency", n, 1);
        check("t1_status_rise", status_out, 1);
        @(negedge clk_100KHz);
        check("t1_ack_one_cycle", ack_out, 0);
        st = 1;
        while (status_out && st < 50) begin
            st++;
            @(negedge clk_100KHz);
        end
        check("t1_status_cycles", st, 9 + PAR);
        wait_idle();
        check("t1_ack_count", ack_cnt - ack0, 1);

        // Sustained valid: 0x3C then 0xFF, captures one period apart.
        ack0     = ack_cnt;
        data_in  = 8'h3C;
        valid_in = 1'b1;
        push_exp(8'h3C, 1'b0);
        wait_ack(n);
        data_in = 8'hFF;
        push_exp(8'hFF, 1'b0);
        wait_ack(n);
        check("t2_capture_spacing", n, 10 + PAR);
        valid_in = 1'b0;
        data_in  = 8'h00;
        wait_idle();
        repeat (5) @(negedge clk_100KHz);
        check("t2_ack_count", ack_cnt - ack0, 2);

        // Reset during 0x81 after its third bit: outputs clear without waiting for a clock.
        ack0     = ack_cnt;
        data_in  = 8'h81;
        valid_in = 1'b1;
        wait_ack(n);
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (2) @(negedge clk_100KHz);
        @(posedge clk_100KHz);
        #1000;
        check("t3_mid_frame_write", write_out, 1);
        reset = 1'b0;
        #10;
        check("t3_async_ack", ack_out, 0);
        check("t3_async_data", data_out, 0);
        check("t3_async_write", write_out, 0);
        check("t3_async_status", status_out, 0);
        repeat (2) @(negedge clk_100KHz);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (15) begin
            @(negedge clk_100KHz);
            if (write_out || status_out) seen = 1'b1;
        end
        check("t3_line_stays_idle", seen, 0);
        check("t3_ack_count", ack_cnt - ack0, 1);

        // valid pulses during SHIFT and during GAP must be ignored.
        ack0     = ack_cnt;
        data_in  = 8'hC3;
        valid_in = 1'b1;
        push_exp(8'hC3, 1'b0);
        wait_ack(n);
        valid_in = 1'b0;
        repeat (3) @(negedge clk_100KHz);
        data_in  = 8'h0F;
        valid_in = 1'b1;
        @(negedge clk_100KHz);
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (4 + PAR) @(negedge clk_100KHz);
        check("t4_in_gap_write", write_out, 0);
        check("t4_in_gap_status", status_out, 1);
        data_in  = 8'h0F;
        valid_in = 1'b1;
        @(negedge clk_100KHz);
        valid_in = 1'b0;
        data_in  = 8'h00;
        wait_idle();
        repeat (3) @(negedge clk_100KHz);
        check("t4_ack_count", ack_cnt - ack0, 1);

        // Parity vectors and loopback byte sequence.
        send(8'h07, 1'b1);
        send(8'h03, 1'b0);
        send(8'h00, 1'b0);
        send(8'h81, 1'b0);
        send(8'hFF, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk_100KHz);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (3) @(negedge clk_100KHz);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
